// File: rtl/mp_driver.sv
// Sweep driver for a microprogram unit: resets it per input combination,
// holds x1/x2, and shifts RUN_LEN response bits into a reported signature.
module mp_driver #(
    parameter int RUN_LEN = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               single,
    input  logic [1:0]         sel,
    output logic               mp_reset,
    output logic               mp_x1,
    output logic               mp_x2,
    input  logic               mp_out,
    output logic [RUN_LEN-1:0] sig,
    output logic [1:0]         sig_idx,
    output logic               sig_valid,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(RUN_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_REPORT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic               single_q, single_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RUN_LEN-1:0] sig_q, sig_d;
    logic [1:0]         idx_q, idx_d;
    logic               active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= 2'd0;
            single_q <= 1'b0;
            cnt_q    <= '0;
            sig_q    <= '0;
            idx_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            single_q <= single_d;
            cnt_q    <= cnt_d;
            sig_q    <= sig_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        single_d = single_q;
        cnt_d    = cnt_q;
        sig_d    = sig_q;
        idx_d    = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RST;
                    k_d      = single ? sel : 2'd0;
                    single_d = single;
                end
            end
            S_RST: begin
                sig_d   = '0;
                cnt_d   = '0;
                idx_d   = k_q;
                state_d = S_RUN;
            end
            S_RUN: begin
                sig_d = {sig_q[RUN_LEN-2:0], mp_out};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(RUN_LEN - 1)) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (!single_q && (k_q != 2'd3)) begin
                    k_d     = k_q + 2'd1;
                    state_d = S_RST;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // k only returns to 0 here, never by incrementing past 3
                k_d     = 2'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign active = (state_q == S_RST) ||
                    (state_q == S_RUN) ||
                    (state_q == S_REPORT);

    always_comb begin
        mp_x1 = 1'b0;
        mp_x2 = 1'b0;
        if (active) begin
            unique case (k_q)
                2'd0: {mp_x1, mp_x2} = 2'b01;
                2'd1: {mp_x1, mp_x2} = 2'b00;
                2'd2: {mp_x1, mp_x2} = 2'b11;
                2'd3: {mp_x1, mp_x2} = 2'b10;
                default: {mp_x1, mp_x2} = 2'b00;
            endcase
        end
    end

    assign mp_reset  = (state_q == S_RST);
    assign sig       = sig_q;
    assign sig_idx   = idx_q;
    assign sig_valid = (state_q == S_REPORT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mp_driver.sv
// Directed bench for mp_driver: sweep table plus reset and
// start-priority sequences.
module tb_mp_driver;

    logic       clk = 1'b0;
    logic       reset, start, single;
    logic [1:0] sel;
    logic       mp_reset, mp_x1, mp_x2, mp_out;
    logic [5:0] sig;
    logic [1:0] sig_idx;
    logic       sig_valid, busy, done;

    int   mode;
    logic patbit;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (mode == 0) mp_out = mp_x2;
        else if (mode == 1) mp_out = mp_x1;
        else mp_out = patbit;
    end

    mp_driver #(.RUN_LEN(6)) dut (
        .clk(clk), .reset(reset), .start(start),
        .single(single), .sel(sel),
        .mp_reset(mp_reset), .mp_x1(mp_x1), .mp_x2(mp_x2),
        .mp_out(mp_out), .sig(sig), .sig_idx(sig_idx),
        .sig_valid(sig_valid), .busy(busy), .done(done)
    );

    typedef struct {
        logic             single;
        logic [1:0]       sel;
        int               mode;
        logic [5:0]       pat;
        logic             poke;
        int               nv;
        logic [3:0][1:0]  idx;
        logic [3:0][5:0]  sg;
        logic [3:0][7:0]  vc;
        int               dc;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_x(input logic [1:0] k);
        case (k)
            2'd0: return 2'b01;
            2'd1: return 2'b00;
            2'd2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int vcnt = 0;
        int dcnt = 0;
        int rcnt = 0;
        int berr = 0;
        int xerr = 0;
        @(negedge clk);
        mode   = v.mode;
        patbit = 1'b0;
        single = v.single;
        sel    = v.sel;
        start  = 1'b1;
        for (int off = 1; off <= v.dc + 3; off++) begin
            @(negedge clk);
            start  = v.poke && (off == 4 || off == v.dc);
            patbit = (v.mode == 2 && off >= 2 && off <= 7) ?
                     v.pat[7-off] : 1'b0;
            if (busy !== (off <= v.dc)) berr++;
            if (mp_reset === 1'b1) rcnt++;
            if (busy && !done && vcnt < v.nv &&
                ({mp_x1, mp_x2} !== exp_x(v.idx[vcnt]))) xerr++;
            if (sig_valid === 1'b1) begin
                if (vcnt < v.nv) begin
                    chk($sformatf("v%0d cyc%0d", id, vcnt), off,
                        int'(v.vc[vcnt]));
                    chk($sformatf("v%0d idx%0d", id, vcnt),
                        int'(sig_idx), int'(v.idx[vcnt]));
                    chk($sformatf("v%0d sig%0d", id, vcnt),
                        int'(sig), int'(v.sg[vcnt]));
                end
                vcnt++;
            end
            if (done === 1'b1) begin
                if (dcnt == 0) chk($sformatf("v%0d done_cyc", id), off, v.dc);
                dcnt++;
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d n_valid", id), vcnt, v.nv);
        chk($sformatf("v%0d n_done", id), dcnt, 1);
        chk($sformatf("v%0d n_mp_reset", id), rcnt, v.nv);
        chk($sformatf("v%0d busy_errs", id), berr, 0);
        chk($sformatf("v%0d x_errs", id), xerr, 0);
        chk($sformatf("v%0d sig_hold", id), int'(sig),
            int'(v.sg[v.nv-1]));
        chk($sformatf("v%0d idx_hold", id), int'(sig_idx),
            int'(v.idx[v.nv-1]));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " mp_reset"}, int'(mp_reset), 0);
        chk({tag, " x1x2"}, int'({mp_x1, mp_x2}), 0);
        chk({tag, " sig"}, int'(sig), 0);
        chk({tag, " sig_idx"}, int'(sig_idx), 0);
        chk({tag, " sig_valid"}, int'(sig_valid), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, nd;
        tbl[0] = '{1'b0, 2'd0, 0, 6'd0, 1'b0, 4,
                   {2'd3, 2'd2, 2'd1, 2'd0},
                   {6'h00, 6'h3F, 6'h00, 6'h3F},
                   {8'd32, 8'd24, 8'd16, 8'd8}, 33};
        tbl[1] = '{1'b0, 2'd0, 0, 6'd0, 1'b1, 4,
                   {2'd3, 2'd2, 2'd1, 2'd0},
                   {6'h00, 6'h3F, 6'h00, 6'h3F},
                   {8'd32, 8'd24, 8'd16, 8'd8}, 33};
        tbl[2] = '{1'b0, 2'd1, 1, 6'd0, 1'b0, 4,
                   {2'd3, 2'd2, 2'd1, 2'd0},
                   {6'h3F, 6'h3F, 6'h00, 6'h00},
                   {8'd32, 8'd24, 8'd16, 8'd8}, 33};
        tbl[3] = '{1'b1, 2'd2, 1, 6'd0, 1'b1, 1,
                   {2'd0, 2'd0, 2'd0, 2'd2},
                   {6'h00, 6'h00, 6'h00, 6'h3F},
                   {8'd0, 8'd0, 8'd0, 8'd8}, 9};
        tbl[4] = '{1'b1, 2'd1, 0, 6'd0, 1'b0, 1,
                   {2'd0, 2'd0, 2'd0, 2'd1},
                   {6'h00, 6'h00, 6'h00, 6'h00},
                   {8'd0, 8'd0, 8'd0, 8'd8}, 9};
        tbl[5] = '{1'b1, 2'd3, 1, 6'd0, 1'b0, 1,
                   {2'd0, 2'd0, 2'd0, 2'd3},
                   {6'h00, 6'h00, 6'h00, 6'h3F},
                   {8'd0, 8'd0, 8'd0, 8'd8}, 9};
        tbl[6] = '{1'b1, 2'd0, 2, 6'b101100, 1'b0, 1,
                   {2'd0, 2'd0, 2'd0, 2'd0},
                   {6'h00, 6'h00, 6'h00, 6'b101100},
                   {8'd0, 8'd0, 8'd0, 8'd8}, 9};

        reset  = 1'b1;
        start  = 1'b0;
        single = 1'b0;
        sel    = 2'd0;
        mode   = 0;
        patbit = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

        // abort in the 3rd RUN cycle of combination 1
        @(negedge clk);
        mode   = 0;
        single = 1'b0;
        start  = 1'b1;
        for (int off = 1; off <= 12; off++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort pre idx", int'(sig_idx), 1);
        chk("abort pre busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("abort");
        nv = 0;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sig_valid === 1'b1) nv++;
            if (done === 1'b1) nd++;
        end
        chk("abort n_valid", nv, 0);
        chk("abort n_done", nd, 0);

        // reset wins over a simultaneous start
        @(negedge clk);
        reset  = 1'b1;
        start  = 1'b1;
        single = 1'b1;
        sel    = 2'd2;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("prio busy", int'(busy), 0);
        chk("prio mp_reset", int'(mp_reset), 0);
        @(negedge clk);
        chk("prio busy2", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
